uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet arbiter feeding a single uart_tx through its send/done handshake.
// Grant is held until the packet's last byte completes or the mid-packet idle timeout fires.
module uart_tx_scheduler #(
   parameter int unsigned NUM_CH  = 4,
   parameter bit          TAG_EN  = 1'b1,
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     req_valid,
   input  logic [8*NUM_CH-1:0]   req_data,
   input  logic [NUM_CH-1:0]     req_last,
   output logic [NUM_CH-1:0]     req_ready,
   output logic [NUM_CH-1:0]     grant,
   output logic                  tx_send,
   output logic [7:0]            tx_data,
   input  logic                  tx_done,
   output logic                  pkt_done,
   output logic                  timeout_flag
);

   localparam int unsigned IDX_W = $clog2(NUM_CH);
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_TAG_WAIT  = 2'd1,
      S_DATA      = 2'd2,
      S_DATA_WAIT = 2'd3
   } state_t;

   state_t             r_state, w_state_n;
   logic [NUM_CH-1:0]  r_grant, w_grant_n;
   logic [IDX_W-1:0]   r_gidx, w_gidx_n;
   logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_n;
   logic               r_last, w_last_n;
   logic               r_tx_send, w_tx_send_n;
   logic [7:0]         r_tx_data, w_tx_data_n;
   logic               r_pkt_done, w_pkt_done_n;
   logic               r_timeout, w_timeout_n;
   logic [CNT_W-1:0]   r_cnt, w_cnt_n;

   logic               w_any;
   logic [IDX_W-1:0]   w_pick;

   // Channel index base+off, wrapped modulo NUM_CH.
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                               input int unsigned      off);
      int unsigned s;
      s = (32'(base) + off) % NUM_CH;
      return IDX_W'(s);
   endfunction

   // First valid channel after the last owner, with wrap-around.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         if (!w_any && req_valid[rr_idx(r_rr_ptr, i)]) begin
            w_any  = 1'b1;
            w_pick = rr_idx(r_rr_ptr, i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_gidx     <= '0;
         r_rr_ptr   <= IDX_W'(NUM_CH - 1);
         r_last     <= 1'b0;
         r_tx_send  <= 1'b0;
         r_tx_data  <= 8'h00;
         r_pkt_done <= 1'b0;
         r_timeout  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_n;
         r_grant    <= w_grant_n;
         r_gidx     <= w_gidx_n;
         r_rr_ptr   <= w_rr_ptr_n;
         r_last     <= w_last_n;
         r_tx_send  <= w_tx_send_n;
         r_tx_data  <= w_tx_data_n;
         r_pkt_done <= w_pkt_done_n;
         r_timeout  <= w_timeout_n;
         r_cnt      <= w_cnt_n;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_grant_n    = r_grant;
      w_gidx_n     = r_gidx;
      w_rr_ptr_n   = r_rr_ptr;
      w_last_n     = r_last;
      w_tx_send_n  = 1'b0;
      w_tx_data_n  = r_tx_data;
      w_pkt_done_n = 1'b0;
      w_timeout_n  = 1'b0;
      w_cnt_n      = r_cnt;

      case (r_state)
         S_IDLE: begin
            w_cnt_n = '0;
            if (w_any) begin
               w_grant_n = NUM_CH'(1) << w_pick;
               w_gidx_n  = w_pick;
               if (TAG_EN) begin
                  w_tx_send_n = 1'b1;
                  w_tx_data_n = 8'hA0 | 8'(w_pick);
                  w_state_n   = S_TAG_WAIT;
               end else begin
                  w_state_n = S_DATA;
               end
            end
         end
         S_TAG_WAIT: begin
            if (tx_done) w_state_n = S_DATA;
         end
         S_DATA: begin
            // ready equals grant here, so valid of the owner alone means a transfer
            if (req_valid[r_gidx]) begin
               w_tx_send_n = 1'b1;
               w_tx_data_n = req_data[{r_gidx, 3'b000} +: 8];
               w_last_n    = req_last[r_gidx];
               w_cnt_n     = '0;
               w_state_n   = S_DATA_WAIT;
            end else if (TIMEOUT != 16'd0) begin
               if (r_cnt + 16'd1 == TIMEOUT) begin
                  w_timeout_n = 1'b1;
                  w_rr_ptr_n  = r_gidx;
                  w_grant_n   = '0;
                  w_cnt_n     = '0;
                  w_state_n   = S_IDLE;
               end else begin
                  w_cnt_n = r_cnt + 16'd1;
               end
            end
         end
         S_DATA_WAIT: begin
            if (tx_done) begin
               if (r_last) begin
                  w_pkt_done_n = 1'b1;
                  w_rr_ptr_n   = r_gidx;
                  w_grant_n    = '0;
                  w_state_n    = S_IDLE;
               end else begin
                  w_state_n = S_DATA;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign req_ready    = (r_state == S_DATA) ? r_grant : '0;
   assign grant        = r_grant;
   assign tx_send      = r_tx_send;
   assign tx_data      = r_tx_data;
   assign pkt_done     = r_pkt_done;
   assign timeout_flag = r_timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: instance a (tag on, TIMEOUT=20) and instance b (tag off, no timeout).
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [3:0]  a_valid, a_last, a_ready, a_grant;
   logic [31:0] a_data;
   logic        a_send, a_done, a_pkt, a_to;
   logic [7:0]  a_tx_data;

   logic [3:0]  b_valid, b_last, b_ready, b_grant;
   logic [31:0] b_data;
   logic        b_send, b_done, b_pkt, b_to;
   logic [7:0]  b_tx_data;

   int errors = 0;
   int checks = 0;
   int a_sends = 0;
   int b_sends = 0;
   int rdy2 = 0;
   int viol1 = 0;
   int n;
   int base;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NUM_CH(4), .TAG_EN(1'b1), .TIMEOUT(16'd20)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_valid), .req_data(a_data), .req_last(a_last), .req_ready(a_ready),
      .grant(a_grant), .tx_send(a_send), .tx_data(a_tx_data), .tx_done(a_done),
      .pkt_done(a_pkt), .timeout_flag(a_to));

   uart_tx_scheduler #(.NUM_CH(4), .TAG_EN(1'b0), .TIMEOUT(16'd0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_valid), .req_data(b_data), .req_last(b_last), .req_ready(b_ready),
      .grant(b_grant), .tx_send(b_send), .tx_data(b_tx_data), .tx_done(b_done),
      .pkt_done(b_pkt), .timeout_flag(b_to));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      a_sends += int'(a_send);
      b_sends += int'(b_send);
      if (a_ready[2]) rdy2++;
      if (a_grant[1] | a_ready[1]) viol1++;
   endtask

   task automatic wait_send(input logic [7:0] exp, input string tag);
      for (int k = 0; k < 50 && !a_send; k++) tick();
      check(tag, {23'd0, a_send, a_tx_data}, {23'd0, 1'b1, exp});
   endtask

   task automatic pulse_done();
      a_done = 1'b1;
      tick();
      a_done = 1'b0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      a_valid = '0; a_last = '0; a_data = '0; a_done = 1'b0;
      b_valid = '0; b_last = '0; b_data = '0; b_done = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      check("rst_grant", {28'd0, a_grant}, 32'd0);
      check("rst_send", {31'd0, a_send}, 32'd0);
      check("rst_data", {24'd0, a_tx_data}, 32'd0);
      check("rst_flags", {30'd0, a_pkt, a_to}, 32'd0);
      check("rst_ready", {28'd0, a_ready}, 32'd0);

      // single-byte packet on ch2 with tag
      rdy2 = 0;
      a_valid = 4'b0100; a_last = 4'b0100; a_data = 32'h005A_0000;
      wait_send(8'hA2, "one_tag");
      check("one_grant", {28'd0, a_grant}, 32'h4);
      tick(); tick();
      check("one_tag_hold", {31'd0, a_send}, 32'd0);
      pulse_done();
      wait_send(8'h5A, "one_data");
      a_valid = '0;
      tick();
      pulse_done();
      check("one_pkt", {31'd0, a_pkt}, 32'd1);
      check("one_grant_clr", {28'd0, a_grant}, 32'd0);
      tick();
      check("one_pkt_pulse", {31'd0, a_pkt}, 32'd0);
      check("one_ready_cycles", 32'(rdy2), 32'd1);

      // round robin with all channels holding one-byte packets
      do_reset();
      a_valid = 4'b1111; a_last = 4'b1111; a_data = 32'h1312_1110;
      for (int i = 0; i < 5; i++) begin
         wait_send(8'hA0 | 8'(i % 4), "rr_tag");
         check("rr_grant", {28'd0, a_grant}, 32'(1 << (i % 4)));
         pulse_done();
         wait_send(8'h10 + 8'(i % 4), "rr_data");
         pulse_done();
         check("rr_pkt", {31'd0, a_pkt}, 32'd1);
      end

      // packet lock: ch0 three bytes while ch1 waits
      do_reset();
      a_valid = 4'b0011; a_last = 4'b0010; a_data = 32'h0000_77C0;
      wait_send(8'hA0, "lock_tag0");
      viol1 = 0;
      pulse_done();
      for (int k = 0; k < 3; k++) begin
         wait_send(8'hC0 + 8'(k), "lock_byte");
         if (k < 2) begin
            a_data[7:0] = 8'hC1 + 8'(k);
            a_last[0]   = (k == 1);
         end else begin
            a_valid[0] = 1'b0;
         end
         pulse_done();
      end
      check("lock_pkt", {31'd0, a_pkt}, 32'd1);
      check("lock_no_ch1", 32'(viol1), 32'd0);
      wait_send(8'hA1, "lock_tag1");
      check("lock_grant1", {28'd0, a_grant}, 32'h2);
      pulse_done();
      wait_send(8'h77, "lock_ch1_data");
      a_valid = '0;
      pulse_done();
      check("lock_pkt1", {31'd0, a_pkt}, 32'd1);

      // timeout: ch1 stalls mid-packet, ch2 waits
      do_reset();
      a_valid = 4'b0110; a_last = 4'b0100; a_data = 32'h0042_3100;
      wait_send(8'hA1, "to_tag");
      pulse_done();
      wait_send(8'h31, "to_data");
      a_valid[1] = 1'b0;
      pulse_done();
      base = a_sends;
      n = 0;
      while (!a_to && n < 40) begin
         tick();
         n++;
      end
      check("to_cycles", 32'(n), 32'd20);
      check("to_grant_clr", {28'd0, a_grant}, 32'd0);
      check("to_no_tail", 32'(a_sends - base), 32'd0);
      tick();
      check("to_pulse", {31'd0, a_to}, 32'd0);
      wait_send(8'hA2, "to_next_tag");
      check("to_next_grant", {28'd0, a_grant}, 32'h4);
      pulse_done();
      wait_send(8'h42, "to_next_data");
      a_valid = '0;
      pulse_done();

      // reset while waiting for a data byte to complete
      do_reset();
      a_valid = 4'b0010; a_last = 4'b0000; a_data = 32'h0000_5500;
      wait_send(8'hA1, "mid_tag");
      pulse_done();
      wait_send(8'h55, "mid_data");
      rst_n = 1'b0;
      a_valid = 4'b1111; a_last = 4'b1111; a_data = 32'h4433_2211;
      tick();
      check("mid_rst", {19'd0, a_grant, a_send, a_tx_data}, 32'd0);
      rst_n = 1'b1;
      wait_send(8'hA0, "mid_restart");
      check("mid_restart_grant", {28'd0, a_grant}, 32'h1);
      a_valid = '0;
      pulse_done();

      // no tag: back-to-back bytes on ch3
      base = b_sends;
      b_valid = 4'b1000; b_last = 4'b0000; b_data = 32'h0100_0000;
      n = 0;
      while (!b_send && n < 10) begin
         tick();
         n++;
      end
      check("nt_b1", {23'd0, b_send, b_tx_data}, {23'd0, 9'h101});
      b_data[31:24] = 8'h02;
      b_done = 1'b1; tick(); b_done = 1'b0;
      check("nt_gap1", {31'd0, b_send}, 32'd0);
      tick();
      check("nt_b2", {23'd0, b_send, b_tx_data}, {23'd0, 9'h102});
      b_data[31:24] = 8'h03; b_last[3] = 1'b1;
      b_done = 1'b1; tick(); b_done = 1'b0;
      check("nt_gap2", {31'd0, b_send}, 32'd0);
      tick();
      check("nt_b3", {23'd0, b_send, b_tx_data}, {23'd0, 9'h103});
      b_valid = '0;
      b_done = 1'b1; tick(); b_done = 1'b0;
      check("nt_pkt", {31'd0, b_pkt}, 32'd1);
      tick(); tick();
      check("nt_send_count", 32'(b_sends - base), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
